// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// A granted operation is driven to the ALU in the grant cycle and its result
// is captured into a one-entry response register on the next rising edge.
module alu_arbiter #(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [5:0]  req0_opcode,
  input  logic [5:0]  req1_opcode,
  input  logic [31:0] req0_op0,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req1_op0,
  input  logic [31:0] req1_op1,
  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_operand_0,
  output logic [31:0] alu_operand_1,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_err
);

  localparam logic RrInitBit = (RR_INIT != 0);

  localparam logic [5:0] OpAdd = 6'd0;
  localparam logic [5:0] OpSub = 6'd1;
  localparam logic [5:0] OpAnd = 6'd2;
  localparam logic [5:0] OpOr  = 6'd3;
  localparam logic [5:0] OpXor = 6'd4;
  localparam logic [5:0] OpSll = 6'd6;
  localparam logic [5:0] OpSrl = 6'd7;
  localparam logic [5:0] OpSra = 6'd8;

  logic        ptr_q, ptr_d;
  logic        rspValid_q, rspValid_d;
  logic        rspId_q, rspId_d;
  logic [31:0] rspResult_q, rspResult_d;
  logic        rspErr_q, rspErr_d;

  logic        slotFree;
  logic        grant0;
  logic        grant1;
  logic        opLegal;

  // Grant decision: the response slot must be free; with both requesters
  // valid the pointer breaks the tie, a lone requester wins outright.
  always_comb begin
    slotFree = !rspValid_q || rsp_ready;
    grant0   = !rst && slotFree && req0_valid && (!req1_valid || (ptr_q == 1'b0));
    grant1   = !rst && slotFree && req1_valid && (!req0_valid || (ptr_q == 1'b1));
  end

  // Steer the granted requester onto the shared ALU, zero when idle.
  always_comb begin
    alu_opcode    = 6'd0;
    alu_operand_0 = 32'd0;
    alu_operand_1 = 32'd0;
    if (grant0) begin
      alu_opcode    = req0_opcode;
      alu_operand_0 = req0_op0;
      alu_operand_1 = req0_op1;
    end else if (grant1) begin
      alu_opcode    = req1_opcode;
      alu_operand_0 = req1_op0;
      alu_operand_1 = req1_op1;
    end
  end

  // Flag opcodes the ALU does not implement; they still issue normally.
  always_comb begin
    case (alu_opcode)
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpSll, OpSrl, OpSra: opLegal = 1'b1;
      default:                                               opLegal = 1'b0;
    endcase
  end

  // Next state of the response slot and the round-robin pointer.
  always_comb begin
    ptr_d       = ptr_q;
    rspValid_d  = rspValid_q;
    rspId_d     = rspId_q;
    rspResult_d = rspResult_q;
    rspErr_d    = rspErr_q;
    if (grant0 || grant1) begin
      rspValid_d  = 1'b1;
      rspId_d     = grant1;
      rspResult_d = alu_result;
      rspErr_d    = !opLegal;
      ptr_d       = !grant1;
    end else if (rsp_ready) begin
      rspValid_d  = 1'b0;
    end
  end

  // State registers; reset discards any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= RrInitBit;
      rspValid_q  <= 1'b0;
      rspId_q     <= 1'b0;
      rspResult_q <= 32'd0;
      rspErr_q    <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rspValid_q  <= rspValid_d;
      rspId_q     <= rspId_d;
      rspResult_q <= rspResult_d;
      rspErr_q    <= rspErr_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rspValid_q;
  assign rsp_id     = rspId_q;
  assign rsp_result = rspResult_q;
  assign rsp_err    = rspErr_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [5:0]  req0_opcode, req1_opcode;
  logic [31:0] req0_op0, req0_op1, req1_op0, req1_op1;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_operand_0, alu_operand_1;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_err;

  int compareCount;
  int mismatchCount;

  alu_arbiter #(.RR_INIT(0)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req1_valid    (req1_valid),
    .req0_ready    (req0_ready),
    .req1_ready    (req1_ready),
    .req0_opcode   (req0_opcode),
    .req1_opcode   (req1_opcode),
    .req0_op0      (req0_op0),
    .req0_op1      (req0_op1),
    .req1_op0      (req1_op0),
    .req1_op1      (req1_op1),
    .alu_opcode    (alu_opcode),
    .alu_operand_0 (alu_operand_0),
    .alu_operand_1 (alu_operand_1),
    .alu_result    (alu_result),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_err       (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU stand-in; unimplemented opcodes return zero.
  always_comb begin
    case (alu_opcode)
      6'd0:    alu_result = alu_operand_0 + alu_operand_1;
      6'd1:    alu_result = alu_operand_0 - alu_operand_1;
      6'd2:    alu_result = alu_operand_0 & alu_operand_1;
      6'd3:    alu_result = alu_operand_0 | alu_operand_1;
      6'd4:    alu_result = alu_operand_0 ^ alu_operand_1;
      6'd6:    alu_result = alu_operand_0 << alu_operand_1[4:0];
      6'd7:    alu_result = alu_operand_0 >> alu_operand_1[4:0];
      6'd8:    alu_result = $unsigned($signed(alu_operand_0) >>> alu_operand_1[4:0]);
      default: alu_result = 32'd0;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(
    input logic v0, input logic [5:0] opc0, input logic [31:0] a0, input logic [31:0] b0,
    input logic v1, input logic [5:0] opc1, input logic [31:0] a1, input logic [31:0] b1,
    input logic rdy);
    req0_valid  = v0;
    req0_opcode = opc0;
    req0_op0    = a0;
    req0_op1    = b0;
    req1_valid  = v1;
    req1_opcode = opc1;
    req1_op0    = a1;
    req1_op1    = b1;
    rsp_ready   = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRsp(input string tag, input logic v, input logic id, input logic [31:0] res, input logic err);
    checkOutput({tag, ".valid"},  {31'd0, rsp_valid}, {31'd0, v});
    checkOutput({tag, ".id"},     {31'd0, rsp_id},    {31'd0, id});
    checkOutput({tag, ".result"}, rsp_result,         res);
    checkOutput({tag, ".err"},    {31'd0, rsp_err},   {31'd0, err});
  endtask

  task automatic checkReady(input string tag, input logic r0, input logic r1);
    checkOutput({tag, ".ready0"}, {31'd0, req0_ready}, {31'd0, r0});
    checkOutput({tag, ".ready1"}, {31'd0, req1_ready}, {31'd0, r1});
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst = 1'b1;
    applyStimulus(1'b1, 6'd0, 32'd1, 32'd1, 1'b1, 6'd0, 32'd2, 32'd2, 1'b1);

    // Reset: no grants, idle ALU, cleared response
    checkReady("rst", 1'b0, 1'b0);
    checkOutput("rst.aluOpnd0", alu_operand_0, 32'd0);
    tick();
    tick();
    checkRsp("rst", 1'b0, 1'b0, 32'd0, 1'b0);

    // Single request: ADD 5,7
    rst = 1'b0;
    applyStimulus(1'b1, 6'd0, 32'd5, 32'd7, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1);
    checkReady("single", 1'b1, 1'b0);
    checkOutput("single.aluOpnd1", alu_operand_1, 32'd7);
    tick();
    checkRsp("single", 1'b1, 1'b0, 32'd12, 1'b0);

    // Illegal opcode from req1 (pointer now at 1)
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 6'd5, 32'd1, 32'd1, 1'b1);
    checkReady("illegal", 1'b0, 1'b1);
    tick();
    checkRsp("illegal", 1'b1, 1'b1, 32'd0, 1'b1);

    // Contention: pointer at 0, expect grants 0,1,0,1 back-to-back
    applyStimulus(1'b1, 6'd0, 32'd1, 32'd2, 1'b1, 6'd4, 32'hF0, 32'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkReady($sformatf("contend%0d", i), (i % 2) == 0, (i % 2) == 1);
      tick();
      checkRsp($sformatf("contend%0d", i), 1'b1, (i % 2) == 1,
               ((i % 2) == 0) ? 32'd3 : 32'h0000000F, 1'b0);
    end

    // Shifts
    applyStimulus(1'b1, 6'd8, 32'h80000000, 32'd4, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1);
    tick();
    checkRsp("sra", 1'b1, 1'b0, 32'hF8000000, 1'b0);
    applyStimulus(1'b1, 6'd7, 32'h80000000, 32'd4, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1);
    tick();
    checkRsp("srl", 1'b1, 1'b0, 32'h08000000, 1'b0);

    // Backpressure: response held, req1 stalls, then granted same cycle as ready
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 6'd1, 32'd3, 32'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkReady($sformatf("stall%0d", i), 1'b0, 1'b0);
      checkOutput($sformatf("stall%0d.aluOpc", i), {26'd0, alu_opcode}, 32'd0);
      tick();
      checkRsp($sformatf("stall%0d", i), 1'b1, 1'b0, 32'h08000000, 1'b0);
    end
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b1, 6'd1, 32'd3, 32'd5, 1'b1);
    checkReady("release", 1'b0, 1'b1);
    tick();
    checkRsp("release", 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0);

    // Drain with no requests, then idle with ready low
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b1);
    checkReady("drain", 1'b0, 1'b0);
    tick();
    checkOutput("drain.valid", {31'd0, rsp_valid}, 32'd0);
    applyStimulus(1'b0, 6'd0, 32'd0, 32'd0, 1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    tick();
    checkOutput("idle.valid", {31'd0, rsp_valid}, 32'd0);

    // Pointer held through idle cycles: still at 0
    applyStimulus(1'b1, 6'd0, 32'd1, 32'd2, 1'b1, 6'd4, 32'hF0, 32'hFF, 1'b0);
    checkReady("hold", 1'b1, 1'b0);
    tick();
    checkRsp("hold", 1'b1, 1'b0, 32'd3, 1'b0);

    // Mid-operation reset with pointer at 1 and a pending response
    rst = 1'b1;
    applyStimulus(1'b1, 6'd0, 32'd1, 32'd2, 1'b1, 6'd4, 32'hF0, 32'hFF, 1'b1);
    checkReady("midrst", 1'b0, 1'b0);
    checkOutput("midrst.aluOpnd0", alu_operand_0, 32'd0);
    tick();
    checkRsp("midrst", 1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 6'd0, 32'd1, 32'd2, 1'b1, 6'd4, 32'hF0, 32'hFF, 1'b1);
    checkReady("postrst", 1'b1, 1'b0);
    tick();
    checkRsp("postrst", 1'b1, 1'b0, 32'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
